// File: rtl/regfile_sequencer_pkg.sv
// Shared definitions for the register-file sequencer.
// Holds the default datapath widths, the instruction kind codes seen on
// instr_kind and the controller state encoding, plus a small helper that
// maps an accepted instruction kind onto the first state of its sequence.
package regfile_sequencer_pkg;

   localparam int DEF_WORD_SIZE     = 16;
   localparam int DEF_REG_ADDR_SIZE = 3;
   localparam int REG_NUM           = 1 << DEF_REG_ADDR_SIZE;

   typedef enum logic [1:0] {
      KIND_ALU   = 2'b00,
      KIND_LOADI = 2'b01,
      KIND_CLEAR = 2'b10,
      KIND_MOVE  = 2'b11
   } kind_e;

   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_IDLE    = 3'd1,
      ST_READ    = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_EXEC    = 3'd4,
      ST_WRITE   = 3'd5,
      ST_CLEAR   = 3'd6
   } state_e;

   // ALU and MOVE both need their sources read first; LOADI goes straight
   // to the write-back and CLEAR has its own single-cycle state.
   function automatic state_e kindToState(input kind_e kind);
      state_e firstState;
      case (kind)
         KIND_ALU:   firstState = ST_READ;
         KIND_MOVE:  firstState = ST_READ;
         KIND_LOADI: firstState = ST_WRITE;
         KIND_CLEAR: firstState = ST_CLEAR;
         default:    firstState = ST_IDLE;
      endcase
      return firstState;
   endfunction

endpackage

// File: rtl/regfile_sequencer.sv
// regfile_sequencer
// Per-instruction controller between instruction decode and the register
// file / ALU. Accepts one decoded instruction in IDLE, reads its sources,
// hands operands to the ALU, and writes the destination back, pulsing
// retire when the instruction completes.
//
// Ports:
//   clock, reset_n            clock and asynchronous active-low reset
//   instr_valid/instr_ready   handshake with decode (ready only in IDLE)
//   instr_kind/func/dst/src1/src2/imm   decoded instruction fields
//   rf_num1, rf_num2          register file addresses (num1 shared read/write)
//   rf_get/set/reset_enable   register file strobes
//   rf_set_val                register file write data
//   rf_out1, rf_out2          registered read data (one cycle after get)
//   alu_valid/alu_done        ALU handshake, valid held until done
//   alu_func, alu_a, alu_b    latched function code and operands
//   alu_result                ALU result, captured on alu_done
//   retire, retire_count      completion pulse and wrapping completion count
module regfile_sequencer
   import regfile_sequencer_pkg::*;
#(
   parameter int WORD_SIZE     = DEF_WORD_SIZE,
   parameter int REG_ADDR_SIZE = DEF_REG_ADDR_SIZE,
   parameter int ALU_FUNC_SIZE = 4,
   parameter int COUNT_SIZE    = 16
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     instr_valid,
   output logic                     instr_ready,
   input  logic [1:0]               instr_kind,
   input  logic [ALU_FUNC_SIZE-1:0] instr_func,
   input  logic [REG_ADDR_SIZE-1:0] instr_dst,
   input  logic [REG_ADDR_SIZE-1:0] instr_src1,
   input  logic [REG_ADDR_SIZE-1:0] instr_src2,
   input  logic [WORD_SIZE-1:0]     instr_imm,
   output logic [REG_ADDR_SIZE-1:0] rf_num1,
   output logic [REG_ADDR_SIZE-1:0] rf_num2,
   output logic                     rf_get_enable,
   output logic                     rf_set_enable,
   output logic                     rf_reset_enable,
   output logic [WORD_SIZE-1:0]     rf_set_val,
   input  logic [WORD_SIZE-1:0]     rf_out1,
   input  logic [WORD_SIZE-1:0]     rf_out2,
   output logic                     alu_valid,
   output logic [ALU_FUNC_SIZE-1:0] alu_func,
   output logic [WORD_SIZE-1:0]     alu_a,
   output logic [WORD_SIZE-1:0]     alu_b,
   input  logic                     alu_done,
   input  logic [WORD_SIZE-1:0]     alu_result,
   output logic                     retire,
   output logic [COUNT_SIZE-1:0]    retire_count
);

   state_e                   state_q, state_d;
   logic                     initArmed_q;
   kind_e                    kind_q;
   logic [ALU_FUNC_SIZE-1:0] func_q;
   logic [REG_ADDR_SIZE-1:0] dst_q, src1_q, src2_q;
   logic [WORD_SIZE-1:0]     imm_q;
   logic [WORD_SIZE-1:0]     aluA_q, aluB_q;
   logic [WORD_SIZE-1:0]     result_q;
   logic [COUNT_SIZE-1:0]    retireCount_q;

   // State register. Reset parks the controller in INIT so that every
   // strobe is low while reset_n is held and the abandoned instruction
   // can never reach its write-back.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_INIT;
      end else begin
         state_q <= state_d;
      end
   end

   // INIT spends its first post-reset cycle with all outputs low, then
   // arms; the armed cycle is the one full-cycle register-file clear.
   // Without this, the clear would only last from the asynchronous
   // release to the next edge, i.e. a fraction of a cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         initArmed_q <= 1'b0;
      end else begin
         initArmed_q <= 1'b1;
      end
   end

   // Next-state and strobe decode. All outputs are Moore functions of the
   // current state; everything defaults low so each state only names the
   // strobes it raises. READ and WRITE are distinct states, so get and set
   // can never coincide, and a dst that matches a source is always read
   // before it is overwritten.
   always_comb begin
      state_d         = state_q;
      instr_ready     = 1'b0;
      rf_get_enable   = 1'b0;
      rf_set_enable   = 1'b0;
      rf_reset_enable = 1'b0;
      rf_num1         = '0;
      rf_num2         = '0;
      rf_set_val      = '0;
      alu_valid       = 1'b0;
      retire          = 1'b0;
      case (state_q)
         ST_INIT: begin
            if (initArmed_q) begin
               rf_reset_enable = 1'b1;
               state_d         = ST_IDLE;
            end
         end
         ST_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               state_d = kindToState(kind_e'(instr_kind));
            end
         end
         ST_READ: begin
            rf_get_enable = 1'b1;
            rf_num1       = src1_q;
            rf_num2       = src2_q;
            state_d       = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            state_d = (kind_q == KIND_MOVE) ? ST_WRITE : ST_EXEC;
         end
         ST_EXEC: begin
            alu_valid = 1'b1;
            if (alu_done) begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            rf_set_enable = 1'b1;
            rf_num1       = dst_q;
            retire        = 1'b1;
            state_d       = ST_IDLE;
            case (kind_q)
               KIND_ALU:   rf_set_val = result_q;
               KIND_LOADI: rf_set_val = imm_q;
               KIND_MOVE:  rf_set_val = aluA_q;
               default:    rf_set_val = '0;
            endcase
         end
         ST_CLEAR: begin
            rf_reset_enable = 1'b1;
            retire          = 1'b1;
            state_d         = ST_IDLE;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // Instruction field latch. Fields are captured only on the accepting
   // IDLE cycle so decode is free to change its outputs afterwards.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         kind_q <= KIND_ALU;
         func_q <= '0;
         dst_q  <= '0;
         src1_q <= '0;
         src2_q <= '0;
         imm_q  <= '0;
      end else if (state_q == ST_IDLE && instr_valid) begin
         kind_q <= kind_e'(instr_kind);
         func_q <= instr_func;
         dst_q  <= instr_dst;
         src1_q <= instr_src1;
         src2_q <= instr_src2;
         imm_q  <= instr_imm;
      end
   end

   // Operand capture. The register file answers one cycle after the READ
   // strobe, so CAPTURE is where rf_out is valid. The operands then stay
   // untouched for the whole EXEC wait; MOVE reuses alu_a as its data.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         aluA_q <= '0;
         aluB_q <= '0;
      end else if (state_q == ST_CAPTURE) begin
         aluA_q <= rf_out1;
         aluB_q <= rf_out2;
      end
   end

   // Result capture. alu_done is only honoured in EXEC; a stray done in
   // any other state has no effect on the result or the sequence.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         result_q <= '0;
      end else if (state_q == ST_EXEC && alu_done) begin
         result_q <= alu_result;
      end
   end

   // Retired-instruction counter, stepped on every retire pulse and left
   // to wrap naturally at its width.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         retireCount_q <= '0;
      end else if (state_q == ST_WRITE || state_q == ST_CLEAR) begin
         retireCount_q <= retireCount_q + COUNT_SIZE'(1);
      end
   end

   assign alu_func     = func_q;
   assign alu_a        = aluA_q;
   assign alu_b        = aluB_q;
   assign retire_count = retireCount_q;

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Per-instruction controller that drives the general-purpose register file and hands operands to the ALU. It accepts one decoded instruction at a time, reads source registers, waits for the ALU result and writes the destination register back. It sits between instruction decode (upstream) and the register file and ALU (downstream).

## Interface

Parameters (defaults from parameters.vh):
- WORD_SIZE, from parameters.vh: register and operand width.
- REG_ADDR_SIZE, from parameters.vh: register index width (3 for 8 registers).
- ALU_FUNC_SIZE, 4: width of the ALU function code passed through.
- COUNT_SIZE, 16: width of the retired-instruction counter.

Ports:
- clock  in  1  system clock, all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  decode presents an instruction.
- instr_ready  out  1  sequencer accepts an instruction this cycle.
- instr_kind  in  2  instruction kind: 00 ALU, 01 LOADI, 10 CLEAR, 11 MOVE.
- instr_func  in  ALU_FUNC_SIZE  ALU function code, used by kind ALU only.
- instr_dst, instr_src1, instr_src2  in  REG_ADDR_SIZE each  register indices.
- instr_imm  in  WORD_SIZE  immediate for LOADI.
- rf_num1, rf_num2  out  REG_ADDR_SIZE  register file address ports. num1 is shared by read and write.
- rf_get_enable, rf_set_enable, rf_reset_enable  out  1  register file strobes.
- rf_set_val  out  WORD_SIZE  write data.
- rf_out1, rf_out2  in  WORD_SIZE  registered read data. Valid one cycle after get_enable.
- alu_valid  out  1  operands valid; held until alu_done.
- alu_func  out  ALU_FUNC_SIZE  latched function code.
- alu_a, alu_b  out  WORD_SIZE  latched operands.
- alu_done  in  1  result valid (may arrive in the same cycle as alu_valid).
- alu_result  in  WORD_SIZE  ALU result.
- retire  out  1  one-cycle pulse when an instruction completes.
- retire_count  out  COUNT_SIZE  completed-instruction count, wraps.

## Operation

- States: INIT, IDLE, READ, CAPTURE, EXEC, WRITE, CLEAR.
- **INIT**
  - Entered on reset.
  - Asserts rf_reset_enable for exactly one cycle after reset_n rises, so the register file clears synchronously.
  - Then goes to IDLE.
- **IDLE**
  - instr_ready=1 here only.
  - On instr_valid, latches all instr_* fields. Next state by kind: ALU/MOVE → READ, LOADI → WRITE, CLEAR → CLEAR.
- **READ**
  - rf_get_enable=1, rf_num1=src1, rf_num2=src2.
  - Next state CAPTURE.
- **CAPTURE**
  - Latches rf_out1→alu_a and rf_out2→alu_b.
  - Next state: EXEC for ALU, WRITE for MOVE (write data = latched alu_a).
- **EXEC**
  - alu_valid=1 with stable alu_a, alu_b and alu_func.
  - On alu_done, latches alu_result and goes to WRITE. Waits indefinitely otherwise.
- **WRITE**
  - rf_set_enable=1, rf_num1=dst, rf_set_val = result / imm / alu_a according to kind.
  - retire=1 and retire_count increments.
  - Next state IDLE.
- **CLEAR**
  - rf_reset_enable=1 for one cycle, retire=1, count increments.
  - Next state IDLE.
- Never asserts get_enable and set_enable in the same cycle.
- dst equal to src1 or src2 is legal: the read always precedes the write.
- retire_count wraps from 2^COUNT_SIZE-1 to 0.

## Timing

- Reset values: every output is 0, state is INIT, latched fields are 0. Consequently instr_ready=0 during INIT.
- Latencies from the IDLE acceptance edge (cycle 0) to the WRITE cycle:
  - ALU: cycle 4 when alu_done arrives in the first EXEC cycle; +1 for each additional wait cycle.
  - MOVE: cycle 3.
  - LOADI: cycle 1.
- CLEAR: clear cycle is cycle 1.
- Back-to-back: the next instruction is accepted in the IDLE cycle following WRITE/CLEAR. Throughput for LOADI is one per 2 cycles.
- Mid-operation reset: reset_n low abandons the instruction immediately (asynchronous).
  - No set_enable and no retire are produced.
  - INIT clear follows release.
- alu_done outside EXEC is ignored.

## Structure

- State encodings and instr_kind codes (KIND_ALU, KIND_LOADI, KIND_CLEAR, KIND_MOVE) belong in the shared parameters.vh alongside WORD_SIZE/REG_ADDR_SIZE/REG_NUM.
- Single module, no sub-module. The retire counter is a simple always block.

## Test plan

- **Reset:** release reset_n → rf_reset_enable high exactly one cycle, then instr_ready=1. All other outputs 0 throughout.
- **LOADI then MOVE:**
  - Stimulus: LOADI r3←0x2A, then MOVE r5←r3.
  - Required: set_enable cycles write 0x2A to num1=3, then 0x2A to num1=5. retire_count=2.
- **ALU with wait:**
  - Setup: r1=7, r2=5.
  - Stimulus: ALU func=ADD dst=r1 src=r1,r2, with alu_done held off 3 cycles and alu_result=12.
  - Required: alu_a=7, alu_b=5 stable while alu_valid is high. Writes 12 to r1 at cycle 7.
- **CLEAR:**
  - Stimulus: after loading r0..r7, issue CLEAR.
  - Required: one rf_reset_enable pulse and retire. The next MOVE reads 0.
- **Reset during EXEC:**
  - Stimulus: assert reset_n low while alu_valid=1.
  - Required: no rf_set_enable ever; outputs 0 immediately; INIT clear after release.
- **Counter wrap:**
  - Configuration: COUNT_SIZE=4.
  - Stimulus: 17 LOADIs.
  - Required: retire_count reads 1.
